nco_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer sitting directly upstream of `lut_based_nco`, driving its signed phase-step input. On a start request it latches a start step, stop step, increment and dwell count, then walks the step word from start to stop. Each value is held for a programmable number of clocks, giving single-shot, repeating sawtooth or triangle chirps. When idle, the output step is zero, so the NCO holds its phase.

---
 rtl/nco_sweep_pkg.sv | 9 +
 rtl/sweep_dwell_cnt.sv | 25 ++
 rtl/nco_sweep_ctrl.sv | 110 +++++++++++
 tb/tb_nco_sweep_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/nco_sweep_pkg.sv
// nco_sweep_pkg: shared widths, FSM states and sweep mode codes for nco_sweep_ctrl.
package nco_sweep_pkg;
    localparam int STEP_WIDTH  = 9;
    localparam int DWELL_WIDTH = 16;
    typedef enum logic [1:0] {IDLE, DWELL, HOP} state_t;
    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_SAW    = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;
endpackage

// File: rtl/sweep_dwell_cnt.sv
// sweep_dwell_cnt: dwell counter with a loadable limit, synchronous clear and terminal count.
module sweep_dwell_cnt
    import nco_sweep_pkg::*;
#(
    parameter int WIDTH = DWELL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clr,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);
    logic [WIDTH-1:0] cnt, lim;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            lim <= '0;
        end else begin
            if (load) lim <= limit;
            cnt <= clr ? '0 : cnt + 1'b1;
        end
    end
    assign tc = cnt == lim;
endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: start/stop/increment/dwell frequency sweep sequencer feeding an NCO step input.
// Define NCO_SWEEP_TRIANGLE_EN to build the triangle repeat mode; otherwise mode 10 runs as single.
module nco_sweep_ctrl #(
    parameter int STEP_WIDTH  = nco_sweep_pkg::STEP_WIDTH,
    parameter int DWELL_WIDTH = nco_sweep_pkg::DWELL_WIDTH
) (
    input  logic                         iclk,
    input  logic                         ireset,
    input  logic                         istart,
    input  logic                         iabort,
    input  logic signed [STEP_WIDTH-1:0] istart_step,
    input  logic signed [STEP_WIDTH-1:0] istop_step,
    input  logic [STEP_WIDTH-2:0]        iincr,
    input  logic [DWELL_WIDTH-1:0]       idwell,
    input  logic [1:0]                   imode,
    output logic signed [STEP_WIDTH-1:0] ostep,
    output logic                         obusy,
    output logic                         odone
);
    import nco_sweep_pkg::*;

    state_t state;
    logic signed [STEP_WIDTH-1:0] start_r, stop_r, target, nxt;
    logic [STEP_WIDTH-2:0] incr_r;
    logic [1:0] mode_r;
    logic up, tc, at_end;

    // One extra bit keeps cur +/- incr exact before clamping to the endpoint.
    function automatic logic signed [STEP_WIDTH-1:0] hop_to(
        input logic signed [STEP_WIDTH-1:0] cur,
        input logic signed [STEP_WIDTH-1:0] tgt,
        input logic                         dir_up,
        input logic [STEP_WIDTH-2:0]        inc
    );
        logic signed [STEP_WIDTH:0] c, t, d, n;
        c = $signed({cur[STEP_WIDTH-1], cur});
        t = $signed({tgt[STEP_WIDTH-1], tgt});
        d = $signed({2'b00, inc});
        n = dir_up ? c + d : c - d;
        return (dir_up ? n > t : n < t) ? tgt : n[STEP_WIDTH-1:0];
    endfunction

    assign at_end = ostep == target;
    assign nxt    = hop_to(ostep, target, up, incr_r);

`ifdef NCO_SWEEP_TRIANGLE_EN
    logic signed [STEP_WIDTH-1:0] other;
    assign other = (target == stop_r) ? start_r : stop_r;
`endif

    sweep_dwell_cnt #(.WIDTH(DWELL_WIDTH)) u_cnt (
        .clk  (iclk),
        .rst  (ireset),
        .load (state == IDLE && istart && !iabort),
        .clr  (state != DWELL || tc),
        .limit(idwell),
        .tc   (tc)
    );

    // The hop is folded into the last dwell cycle, so the FSM only visits IDLE and DWELL.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state   <= IDLE;
            ostep   <= '0;
            obusy   <= 1'b0;
            odone   <= 1'b0;
            start_r <= '0;
            stop_r  <= '0;
            target  <= '0;
            incr_r  <= '0;
            mode_r  <= MODE_SINGLE;
            up      <= 1'b1;
        end else begin
            odone <= 1'b0;
            if (iabort) begin
                state <= IDLE;
                ostep <= '0;
                obusy <= 1'b0;
            end else if (state == IDLE) begin
                if (istart) begin
                    start_r <= istart_step;
                    stop_r  <= istop_step;
                    target  <= istop_step;
                    up      <= istop_step >= istart_step;
                    incr_r  <= iincr | {{(STEP_WIDTH-2){1'b0}}, ~|iincr};
                    mode_r  <= imode;
                    ostep   <= istart_step;
                    obusy   <= 1'b1;
                    state   <= DWELL;
                end
            end else if (tc) begin
                if (!at_end) ostep <= nxt;
                else if (mode_r == MODE_SAW) ostep <= start_r;
`ifdef NCO_SWEEP_TRIANGLE_EN
                else if (mode_r == MODE_TRI) begin
                    target <= other;
                    up     <= !up;
                    ostep  <= hop_to(ostep, other, !up, incr_r);
                end
`endif
                else begin
                    odone <= 1'b1;
                    ostep <= '0;
                    obusy <= 1'b0;
                    state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: directed self-checking bench for nco_sweep_ctrl.
module tb_nco_sweep_ctrl;
    logic iclk = 1'b0, ireset = 1'b1, istart = 1'b0, iabort = 1'b0;
    logic signed [8:0] istart_step = '0, istop_step = '0;
    logic [7:0] iincr = '0;
    logic [15:0] idwell = '0;
    logic [1:0] imode = '0;
    logic signed [8:0] ostep;
    logic obusy, odone;
    int checks = 0, errors = 0;

    always #5 iclk = ~iclk;

    nco_sweep_ctrl dut (
        .iclk       (iclk),
        .ireset     (ireset),
        .istart     (istart),
        .iabort     (iabort),
        .istart_step(istart_step),
        .istop_step (istop_step),
        .iincr      (iincr),
        .idwell     (idwell),
        .imode      (imode),
        .ostep      (ostep),
        .obusy      (obusy),
        .odone      (odone)
    );

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge iclk);
        #1;
    endtask

    task automatic check_idle(input string tag, input int done);
        check({tag, "_step"}, int'(ostep), 0);
        check({tag, "_busy"}, int'(obusy), 0);
        check({tag, "_done"}, int'(odone), done);
    endtask

    // Inputs are scrambled after the start edge to prove they were latched.
    task automatic start_sweep(input int s, input int e, input int inc, input int dw, input int m);
        istart_step = s[8:0];
        istop_step  = e[8:0];
        iincr       = inc[7:0];
        idwell      = dw[15:0];
        imode       = m[1:0];
        istart      = 1'b1;
        step;
        istart      = 1'b0;
        istart_step = 9'sd77;
        istop_step  = -9'sd50;
        iincr       = 8'd9;
        idwell      = 16'd4;
        imode       = 2'b11;
    endtask

    task automatic hold(input string tag, input int v, input int n);
        repeat (n) begin
            check({tag, "_step"}, int'(ostep), v);
            check({tag, "_busy"}, int'(obusy), 1);
            check({tag, "_done"}, int'(odone), 0);
            step;
        end
    endtask

    initial begin
        repeat (2) @(posedge iclk);
        #1;
        check_idle("reset", 0);
        ireset = 1'b0;
        step;
        check_idle("post_reset", 0);

        start_sweep(1, 8, 3, 0, 0);
        hold("up1", 1, 1);
        hold("up4", 4, 1);
        hold("up7", 7, 1);
        hold("up8", 8, 1);
        check_idle("up_end", 1);

        start_sweep(-1, -4, 1, 2, 0);
        hold("dn1", -1, 3);
        hold("dn2", -2, 3);
        hold("dn3", -3, 3);
        hold("dn4", -4, 3);
        check_idle("dn_end", 1);
        step;
        check_idle("dn_after", 0);

        start_sweep(0, 2, 1, 0, 1);
        istart = 1'b1;
        for (int k = 0; k < 7; k++) hold("saw", k % 3, 1);
        iabort = 1'b1;
        step;
        check_idle("saw_abort", 0);
        iabort = 1'b0;
        istart = 1'b0;
        step;
        check_idle("saw_idle", 0);

        start_sweep(0, 3, 1, 0, 2);
        hold("tri0", 0, 1);
        hold("tri1", 1, 1);
        hold("tri2", 2, 1);
        hold("tri3", 3, 1);
`ifdef NCO_SWEEP_TRIANGLE_EN
        hold("tri2b", 2, 1);
        hold("tri1b", 1, 1);
        hold("tri0b", 0, 1);
        hold("tri1c", 1, 1);
        iabort = 1'b1;
        step;
        iabort = 1'b0;
        check_idle("tri_abort", 0);
`else
        check_idle("tri_single", 1);
`endif

        start_sweep(0, 3, 0, 0, 1);
        for (int k = 0; k < 6; k++) hold("inc0", k % 4, 1);
        iabort = 1'b1;
        istart = 1'b1;
        step;
        check_idle("abort_start", 0);
        iabort = 1'b0;
        istart = 1'b0;
        step;
        check_idle("abort_idle", 0);

        start_sweep(5, 5, 2, 1, 0);
        hold("eq", 5, 2);
        check_idle("eq_end", 1);

        start_sweep(5, 5, 1, 0, 1);
        hold("rst_run", 5, 3);
        #2 ireset = 1'b1;
        #1;
        check_idle("async_reset", 0);
        @(posedge iclk);
        #1 ireset = 1'b0;
        step;
        check_idle("reset_idle", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
